// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - waveform synthesizer: square/saw/triangle/noise with volume
// Two-stage pipeline: stage 1 shapes the raw sample, stage 2 applies the volume.
module wave_generator #(
  parameter logic [3:0] CTRL_ADDR = 4'h1
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic [15:0] phase_in,
  input  logic        phase_valid_in,
  input  logic [15:0] data_in,
  input  logic [3:0]  addr_in,
  input  logic        data_valid_in,
  output logic [7:0]  sample_out,
  output logic        sample_valid_out
);

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_e;

  logic [15:0] ctrl;
  logic [15:0] lfsr;
  logic [15:0] phase_prev;
  logic [7:0]  raw;
  logic [3:0]  vol1;
  logic        valid1;

  logic [7:0]  raw_next;
  logic [7:0]  tri_t;
  logic [15:0] lfsr_next;
  logic        wrap;
  logic signed [11:0] raw_ext;
  logic signed [11:0] vol_ext;
  logic signed [11:0] prod;
  logic        ctrl_unused;

  // Bits [3:2] of ctrl are reserved and never decoded.
  assign ctrl_unused = ^ctrl[3:2];

  assign wrap      = phase_in < phase_prev;
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    raw_next = 8'h00;
    tri_t    = phase_in[15] ? ~phase_in[14:7] : phase_in[14:7];
    case (wave_e'(ctrl[1:0]))
      WAVE_SQUARE: raw_next = (phase_in[15:8] < ctrl[15:8]) ? 8'h7F : 8'h81;
      WAVE_SAW:    raw_next = {~phase_in[15], phase_in[14:8]};
      WAVE_TRI:    raw_next = tri_t ^ 8'h80;
      WAVE_NOISE:  raw_next = lfsr[7:0];
      default:     raw_next = 8'h00;
    endcase
  end

  // Low 12 bits of the product, then >>>4 and truncate to 8 is just prod[11:4].
  assign raw_ext = {{4{raw[7]}}, raw};
  assign vol_ext = {8'h00, vol1};
  assign prod    = raw_ext * vol_ext;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ctrl             <= 16'h0000;
      lfsr             <= 16'hACE1;
      phase_prev       <= 16'h0000;
      raw              <= 8'h00;
      vol1             <= 4'h0;
      valid1           <= 1'b0;
      sample_out       <= 8'h00;
      sample_valid_out <= 1'b0;
    end else begin
      if (data_valid_in && (addr_in == CTRL_ADDR)) begin
        ctrl <= data_in;
      end
      valid1 <= phase_valid_in;
      if (phase_valid_in) begin
        raw        <= raw_next;
        vol1       <= ctrl[7:4];
        phase_prev <= phase_in;
        if (wrap) begin
          lfsr <= lfsr_next;
        end
      end
      sample_valid_out <= valid1;
      if (valid1) begin
        sample_out <= prod[11:4];
      end
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// tb/tb_wave_generator.sv - directed self-checking bench for wave_generator
module tb_wave_generator;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [15:0] phase_in;
  logic        phase_valid_in;
  logic [15:0] data_in;
  logic [3:0]  addr_in;
  logic        data_valid_in;
  logic [7:0]  sample_out;
  logic        sample_valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  wave_generator #(.CTRL_ADDR(4'h1)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .phase_in         (phase_in),
    .phase_valid_in   (phase_valid_in),
    .data_in          (data_in),
    .addr_in          (addr_in),
    .data_valid_in    (data_valid_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    addr_in = a; data_in = d; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
  endtask

  // Single phase strobe; checks the output pulse two clocks later and its end.
  task automatic one_sample(input string tag, input logic [15:0] ph, input logic [7:0] exp);
    phase_in = ph; phase_valid_in = 1'b1;
    tick();
    phase_valid_in = 1'b0;
    chk({tag, "_v_early"}, {15'd0, sample_valid_out}, 16'd0);
    tick();
    chk({tag, "_valid"}, {15'd0, sample_valid_out}, 16'd1);
    chk({tag, "_sample"}, {8'd0, sample_out}, {8'd0, exp});
    tick();
    chk({tag, "_v_drop"}, {15'd0, sample_valid_out}, 16'd0);
    chk({tag, "_hold"}, {8'd0, sample_out}, {8'd0, exp});
  endtask

  task automatic do_reset();
    reset_n_in = 1'b0;
    tick();
    tick();
    reset_n_in = 1'b1;
    tick();
  endtask

  initial begin
    reset_n_in = 1'b0; phase_in = '0; phase_valid_in = 1'b0;
    data_in = '0; addr_in = '0; data_valid_in = 1'b0;
    #2;
    chk("rst_valid", {15'd0, sample_valid_out}, 16'd0);
    chk("rst_sample", {8'd0, sample_out}, 16'h0000);
    tick();
    reset_n_in = 1'b1;
    tick();

    one_sample("vol0", 16'h4000, 8'h00);

    wr(4'h1, 16'h00F1);
    one_sample("saw_c000", 16'hC000, 8'd60);
    wr(4'h2, 16'h0000);
    one_sample("saw_ignored_addr", 16'hC000, 8'd60);

    // Square at duty 0x80, back-to-back strobes.
    wr(4'h1, 16'h80F0);
    phase_in = 16'h7F00; phase_valid_in = 1'b1;
    tick();
    phase_in = 16'h8000;
    tick();
    phase_valid_in = 1'b0;
    chk("sq_b2b_v0", {15'd0, sample_valid_out}, 16'd1);
    chk("sq_b2b_s0", {8'd0, sample_out}, {8'd0, 8'd119});
    tick();
    chk("sq_b2b_v1", {15'd0, sample_valid_out}, 16'd1);
    chk("sq_b2b_s1", {8'd0, sample_out}, {8'd0, 8'h88});
    tick();
    chk("sq_b2b_vend", {15'd0, sample_valid_out}, 16'd0);

    wr(4'h1, 16'h00F2);
    one_sample("tri_0000", 16'h0000, 8'h88);
    one_sample("tri_4000", 16'h4000, 8'h00);
    one_sample("tri_8000", 16'h8000, 8'd119);

    // Control write on the same edge as a strobe: the sample keeps the old saw.
    wr(4'h1, 16'h00F1);
    phase_in = 16'hC000; phase_valid_in = 1'b1;
    addr_in = 4'h1; data_in = 16'h0002; data_valid_in = 1'b1;
    tick();
    phase_valid_in = 1'b0; data_valid_in = 1'b0;
    tick();
    chk("coincide_sample", {8'd0, sample_out}, {8'd0, 8'd60});
    one_sample("coincide_next_vol0", 16'hC000, 8'h00);

    // Noise from a clean LFSR state.
    do_reset();
    wr(4'h1, 16'h00F3);
    one_sample("noise_f000", 16'hF000, 8'hE2);
    one_sample("noise_wrap", 16'h1000, 8'hE2);
    one_sample("noise_2000", 16'h2000, 8'd105);

    // Reset one clock after a strobe drops the sample.
    wr(4'h1, 16'h00F1);
    phase_in = 16'hC000; phase_valid_in = 1'b1;
    tick();
    phase_valid_in = 1'b0;
    reset_n_in = 1'b0;
    #1;
    chk("midrst_async_sample", {8'd0, sample_out}, 16'h0000);
    tick();
    chk("midrst_valid_in_rst", {15'd0, sample_valid_out}, 16'd0);
    reset_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_pulse", {15'd0, sample_valid_out}, 16'd0);
    end
    chk("midrst_sample", {8'd0, sample_out}, 16'h0000);
    one_sample("post_rst_vol0", 16'h4000, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 4'h1, meaning the addr_in value that selects this block's control register.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port phase_in  input  16  phase accumulator value from the upstream sample counter.
REQ-005 SHALL have port phase_valid_in  input  1  one-cycle strobe qualifying phase_in.
REQ-006 SHALL have port data_in  input  16  register write data.
REQ-007 SHALL have port addr_in  input  4  register write address.
REQ-008 SHALL have port data_valid_in  input  1  register write strobe.
REQ-009 SHALL have port sample_out  output  8  signed two's-complement audio sample, registered.
REQ-010 SHALL have port sample_valid_out  output  1  one-cycle strobe qualifying sample_out, registered.

Function
REQ-011 SHALL write ctrl[15:0] <= data_in on a clock edge where data_valid_in=1 and addr_in=CTRL_ADDR; any other addr_in SHALL be ignored.
REQ-012 SHALL decode ctrl: [1:0] wave (0 square, 1 saw, 2 triangle, 3 noise), [3:2] reserved/ignored, [7:4] volume 0..15, [15:8] duty.
REQ-013 SHALL implement a 2-stage pipeline: stage 1 on phase_valid_in=1 computes raw (8-bit signed) and latches wave-independent volume; stage 2 computes the output.
REQ-014 SHALL assert sample_valid_out exactly 2 clocks after the phase_valid_in edge, for exactly 1 cycle; back-to-back phase_valid_in every cycle SHALL produce back-to-back outputs (throughput 1/clock).
REQ-015 SHALL hold sample_out at its last value when no new sample is produced.
REQ-016 Square: raw = +127 if phase_in[15:8] < duty, else -127 (duty 0 -> always -127).
REQ-017 Saw: raw = phase_in[15:8] - 128, i.e. {~phase_in[15], phase_in[14:8]}.
REQ-018 Triangle: t = phase_in[15] ? ~phase_in[14:7] : phase_in[14:7]; raw = t - 128.
REQ-019 Noise: raw = lfsr[7:0] interpreted as signed, using the LFSR value held before any advance in that cycle.
REQ-020 LFSR SHALL be 16-bit Galois, right-shifting: next = (lfsr>>1) XOR (lfsr[0] ? 16'hB400 : 0).
REQ-021 LFSR SHALL advance once on a phase_valid_in edge where phase_in < phase_prev (wrap); phase_prev SHALL capture phase_in on every phase_valid_in; LFSR advances regardless of selected wave.
REQ-022 Stage 2: sample_out = (raw * vol) arithmetic-shifted right by 4 (floor), computed at 12-bit signed, result truncated to 8 bits (always in range -120..119).
REQ-023 A control write coinciding with phase_valid_in SHALL NOT affect that sample; the new ctrl applies from the next phase_valid_in.
REQ-024 Volume used at stage 2 SHALL be the value latched in stage 1 with the same sample.

Reset
REQ-025 reset_n_in=0 SHALL immediately (asynchronously) set: ctrl=16'h0000, lfsr=16'hACE1, phase_prev=0, raw and pipeline valids=0, sample_out=8'h00, sample_valid_out=0.
REQ-026 Reset asserted mid-pipeline SHALL drop all in-flight samples; no sample_valid_out after release until a new phase_valid_in, 2 clocks later.
REQ-027 Release of reset_n_in SHALL be usable synchronously to clk_in; first edge after release is a normal operating edge.

Verification
REQ-028 Reset, then phase_valid_in with phase 0x4000 -> sample_valid_out pulse 2 clocks later, sample_out=0x00 (volume 0).
REQ-029 Write addr 1 data 0x00F1 (saw, vol 15); phase 0xC000 -> sample_out=60; write addr 2 data 0x0000 -> ctrl unchanged, next phase 0xC000 still 60.
REQ-030 Write 0x80F0 (square, duty 0x80); phases 0x7F00, 0x8000 on consecutive cycles -> sample_out 119 then -120 on consecutive cycles, valid high 2 cycles.
REQ-031 Write 0x00F2 (triangle); phases 0x0000, 0x4000, 0x8000 -> -120, 0, 119.
REQ-032 Write 0x00F3 (noise); phases 0xF000 then 0x1000 (wrap) then 0x2000 -> samples -30, -30, 105 (LFSR 0xACE1 -> 0xE270).
REQ-033 Assert reset_n_in one clock after a phase_valid_in -> sample_valid_out never pulses for that sample; sample_out=0x00.
